sample_packer: RTL and testbench

- Downstream stage of the 3-bit registered mux/selector stage. Consumes its 3-bit sample stream and packs PACK_N consecutive samples into one word.
- Presents each word on a valid/ready output with back-pressure to the upstream source.
- Supports an explicit flush that emits a partial, zero-padded word.
- Sits between the sample selector and any word-wide sink (FIFO, bus writer).

---
 rtl/sample_packer_pkg.sv | 21 ++
 rtl/packer_out_slot.sv | 65 ++++++
 rtl/sample_packer.sv | 112 +++++++++++
 tb/tb_sample_packer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_packer_pkg.sv
// Shared defaults and derived-width helpers for the sample packer.
// The parity helper is used when SAMPLE_PACKER_PARITY_EN is defined.
package sample_packer_pkg;

  localparam int SAMPLE_W_DEF = 3;
  localparam int PACK_N_DEF   = 5;
  localparam int PARITY_MAX_W = 64;

  function automatic int word_width(input int sample_w, input int pack_n);
    return sample_w * pack_n;
  endfunction

  function automatic int len_width(input int pack_n);
    return $clog2(pack_n + 1);
  endfunction

  function automatic logic xor_parity(input logic [PARITY_MAX_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/packer_out_slot.sv
// Output word register with valid/ready hold; adds o_parity when
// SAMPLE_PACKER_PARITY_EN is defined.
module packer_out_slot
  import sample_packer_pkg::*;
#(
  parameter int WORD_W = 15,
  parameter int LEN_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              i_ready,
  output logic              slot_free,
  output logic [WORD_W-1:0] o_data,
  output logic [LEN_W-1:0]  o_len,
`ifdef SAMPLE_PACKER_PARITY_EN
  output logic              o_parity,
`endif
  output logic              o_valid
);

  logic [WORD_W-1:0] data_r;
  logic [LEN_W-1:0]  len_r;
  logic              valid_r;

  // A new word may only land when the slot is empty or draining this cycle.
  assign slot_free = !valid_r || i_ready;

  // Word register: load replaces, an accepted word without reload empties the slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_r  <= '0;
      len_r   <= '0;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      len_r   <= load_len;
      valid_r <= 1'b1;
    end else if (i_ready) begin
      valid_r <= 1'b0;
    end
  end

`ifdef SAMPLE_PACKER_PARITY_EN
  logic parity_r;

  // Parity travels with the word so it stays consistent while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      parity_r <= 1'b0;
    end else if (load) begin
      parity_r <= xor_parity(PARITY_MAX_W'(load_data));
    end
  end

  assign o_parity = parity_r;
`endif

  assign o_data  = data_r;
  assign o_len   = len_r;
  assign o_valid = valid_r;

endmodule

// File: rtl/sample_packer.sv
// Packs PACK_N narrow samples into one word with valid/ready output and flush.
// Optional o_parity port is enabled by SAMPLE_PACKER_PARITY_EN.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter  int SAMPLE_W = SAMPLE_W_DEF,
  parameter  int PACK_N   = PACK_N_DEF,
  localparam int WORD_W   = word_width(SAMPLE_W, PACK_N),
  localparam int LEN_W    = len_width(PACK_N)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_flush,
  output logic [WORD_W-1:0]   o_data,
  output logic [LEN_W-1:0]    o_len,
  output logic                o_valid,
`ifdef SAMPLE_PACKER_PARITY_EN
  output logic                o_parity,
`endif
  input  logic                i_ready
);

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(PACK_N - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PACK_N);

  logic [WORD_W-1:0] acc_r;
  logic [LEN_W-1:0]  cnt_r;
  logic              flush_pend_r;

  logic              slot_free_s;
  logic              ready_s;
  logic              accept_s;
  logic              complete_s;
  logic              flush_req_s;
  logic [WORD_W-1:0] acc_ins_s;
  logic [LEN_W-1:0]  cnt_ins_s;
  logic              load_s;
  logic [LEN_W-1:0]  load_len_s;

  // Stall only on a completing sample into an occupied slot, or while a flush waits.
  assign ready_s     = !flush_pend_r && (slot_free_s || (cnt_r != LAST_IDX));
  assign accept_s    = i_valid && ready_s;
  assign complete_s  = accept_s && (cnt_r == LAST_IDX);
  assign flush_req_s = i_flush || flush_pend_r;
  assign o_ready     = ready_s;

  // Accumulator and count as they would be after this cycle's accept.
  always_comb begin
    acc_ins_s = '0;
    for (int i = 0; i < PACK_N; i++) begin
      acc_ins_s[i*SAMPLE_W +: SAMPLE_W] = (accept_s && (cnt_r == LEN_W'(i))) ?
                                          i_data : acc_r[i*SAMPLE_W +: SAMPLE_W];
    end
    cnt_ins_s = accept_s ? (cnt_r + LEN_W'(1)) : cnt_r;
  end

  // A full word always ships; a flush ships the partial word only if non-empty.
  always_comb begin
    load_s     = 1'b0;
    load_len_s = '0;
    if (complete_s) begin
      load_s     = 1'b1;
      load_len_s = FULL_LEN;
    end else if (flush_req_s && slot_free_s && (cnt_ins_s != '0)) begin
      load_s     = 1'b1;
      load_len_s = cnt_ins_s;
    end else begin
      load_s     = 1'b0;
      load_len_s = '0;
    end
  end

  // Accumulator, fill count and pending-flush state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_r        <= '0;
      cnt_r        <= '0;
      flush_pend_r <= 1'b0;
    end else if (load_s) begin
      acc_r        <= '0;
      cnt_r        <= '0;
      flush_pend_r <= 1'b0;
    end else begin
      acc_r        <= acc_ins_s;
      cnt_r        <= cnt_ins_s;
      flush_pend_r <= flush_req_s && !slot_free_s;
    end
  end

  packer_out_slot #(
    .WORD_W (WORD_W),
    .LEN_W  (LEN_W)
  ) u_slot (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .load      (load_s),
    .load_data (acc_ins_s),
    .load_len  (load_len_s),
    .i_ready   (i_ready),
    .slot_free (slot_free_s),
    .o_data    (o_data),
    .o_len     (o_len),
`ifdef SAMPLE_PACKER_PARITY_EN
    .o_parity  (o_parity),
`endif
    .o_valid   (o_valid)
  );

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: directed scenarios plus a random run
// against a queue-based reference model.
module tb_sample_packer;

  localparam int SW = 3;
  localparam int PN = 5;
  localparam int WW = 15;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [SW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          i_flush = 1'b0;
  logic [WW-1:0] o_data;
  logic [2:0]    o_len;
  logic          o_valid;
  logic          i_ready = 1'b1;
`ifdef SAMPLE_PACKER_PARITY_EN
  logic          o_parity;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sample_packer dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_flush (i_flush),
    .o_data  (o_data),
    .o_len   (o_len),
    .o_valid (o_valid),
`ifdef SAMPLE_PACKER_PARITY_EN
    .o_parity(o_parity),
`endif
    .i_ready (i_ready)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: queue of pending samples plus the output slot contents.
  int            mq[$];
  bit            mv = 1'b0;
  logic [WW-1:0] md = '0;
  logic [2:0]    ml = '0;
  bit            mp = 1'b0;

  function automatic logic [WW-1:0] pack_q(input int s[$]);
    int w;
    w = 0;
    for (int i = 0; i < s.size(); i++) w = w + s[i] * (1 << (SW * i));
    return WW'(w);
  endfunction

  function automatic bit m_ready();
    return !mp && ((!mv || i_ready) || (mq.size() != PN - 1));
  endfunction

  always @(posedge i_clk) begin
    bit free, acc, freq, emit;
    if (i_rst) begin
      mq.delete(); mv = 1'b0; md = '0; ml = '0; mp = 1'b0;
    end else begin
      free = !mv || i_ready;
      acc  = i_valid && m_ready();
      freq = i_flush || mp;
      if (acc) mq.push_back(int'(i_data));
      emit = (mq.size() == PN) || (freq && free && mq.size() > 0);
      if (emit) begin
        md = pack_q(mq); ml = 3'(mq.size()); mv = 1'b1; mq.delete();
      end else if (i_ready) begin
        mv = 1'b0;
      end
      mp = freq && !free;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_data = 3'd6; i_flush = 1'b1;
    tick(); tick();
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b0 || o_len !== 3'd0 || o_data !== 15'h0000) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b len=%0d data=%h, want 0/0/0000", o_valid, o_len, o_data);
    end
    i_rst = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    #1;
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: o_ready=%b want 1", o_ready);
    end
    tick();
  endtask

  task automatic test_full_word(input string tag);
    for (int k = 1; k <= PN; k++) begin
      i_valid = 1'b1; i_data = 3'(k);
      @(negedge i_clk);
      n_cmp++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_fill: ready=%b valid=%b at sample %0d, want 1/0", tag, o_ready, o_valid, k);
      end
      tick();
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 15'h58D1 || o_len !== 3'd5) begin
      n_bad++;
      $display("FAIL %s_word: valid=%b data=%h len=%0d, want 1/58d1/5", tag, o_valid, o_data, o_len);
    end
`ifdef SAMPLE_PACKER_PARITY_EN
    n_cmp++;
    if (o_parity !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_parity: o_parity=%b want 1", tag, o_parity);
    end
`endif
    tick();
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain: o_valid=%b want 0", tag, o_valid);
    end
    tick();
  endtask

  task automatic test_flush();
    i_valid = 1'b1; i_data = 3'd7; tick();
    i_data = 3'd6; tick();
    i_valid = 1'b0; i_flush = 1'b1; tick();
    i_flush = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== 15'h0037 || o_len !== 3'd2) begin
      n_bad++;
      $display("FAIL flush_partial: valid=%b data=%h len=%0d, want 1/0037/2", o_valid, o_data, o_len);
    end
    tick();
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_single: o_valid=%b want 0", o_valid);
    end
    tick();
    test_full_word("after_flush");
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] w1, w2;
    int a[$];
    int b[$];
    i_ready = 1'b0;
    for (int k = 0; k < 2 * PN; k++) begin
      i_valid = 1'b1; i_data = 3'($urandom_range(0, 7));
      if (k < PN) a.push_back(int'(i_data)); else b.push_back(int'(i_data));
      @(negedge i_clk);
      if (k != 2 * PN - 1) begin
        n_cmp++;
        if (o_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_accept: o_ready=%b at sample %0d, want 1", o_ready, k);
        end
        tick();
      end
    end
    w1 = pack_q(a);
    w2 = pack_q(b);
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== w1) begin
        n_bad++;
        $display("FAIL b2b_stall: ready=%b valid=%b data=%h, want 0/1/%h", o_ready, o_valid, o_data, w1);
      end
      tick();
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    #1;
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_release: o_ready=%b want 1", o_ready);
    end
    tick();
    i_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b1 || o_data !== w2 || o_len !== 3'd5) begin
      n_bad++;
      $display("FAIL b2b_second: valid=%b data=%h len=%0d, want 1/%h/5", o_valid, o_data, o_len, w2);
    end
    tick();
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain: o_valid=%b want 0", o_valid);
    end
    tick();
  endtask

  task automatic test_empty_flush();
    i_valid = 1'b0; i_flush = 1'b1; tick();
    i_flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL empty_flush: valid=%b ready=%b, want 0/1", o_valid, o_ready);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = 3'd7; tick();
    end
    i_valid = 1'b0; i_rst = 1'b1; tick();
    @(negedge i_clk);
    n_cmp++;
    if (o_valid !== 1'b0 || o_len !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_mid: valid=%b len=%0d, want 0/0", o_valid, o_len);
    end
    i_rst = 1'b0;
    tick();
    test_full_word("post_reset");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = 3'($urandom_range(0, 7));
      i_flush = ($urandom_range(0, 9) == 0);
      i_ready = ($urandom_range(0, 9) < 7);
      @(negedge i_clk);
      n_cmp++;
      if (o_ready !== m_ready() || o_valid !== mv || o_data !== md || o_len !== ml) begin
        n_bad++;
        $display("FAIL random_c%0d: ready=%b valid=%b data=%h len=%0d, want %b/%b/%h/%0d",
                 c, o_ready, o_valid, o_data, o_len, m_ready(), mv, md, ml);
      end
`ifdef SAMPLE_PACKER_PARITY_EN
      n_cmp++;
      if (o_parity !== ^md) begin
        n_bad++;
        $display("FAIL random_parity_c%0d: o_parity=%b want %b", c, o_parity, ^md);
      end
`endif
      tick();
    end
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_word("first_word");
    test_flush();
    test_back_to_back();
    test_empty_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
